render_cmd_decoder: RTL and testbench
=====================================

# render_cmd_decoder

Consumer end of the VGA render queue. The HPS writes render commands into the queue one byte at a time. Each command is a sync byte followed by five payload bytes. This block pops the queue and reassembles each command into one parallel sprite-draw command. It hands that command to the display pipeline over a valid/ready handshake. It sits between the `vga_render_q` FIFO output and the sprite renderer in the `clk50` domain.

## Interface
Parameters:
- `SYNC_BYTE`, 8'hFF: packet start marker.
- `H_RES`, 640: horizontal resolution; x must be < `H_RES`.
- `V_RES`, 480: vertical resolution; y must be < `V_RES`.

Ports:
- `clk50`, in, 1: single clock; every register is on its rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `q_dout`, in, 8: byte at the front of the render queue; valid whenever `q_empty` = 0.
- `q_empty`, in, 1: render queue empty.
- `q_pop_front`, out, 1: one-cycle pulse; removes the front byte. `q_dout` shows the next byte on the following cycle.
- `cmd_valid`, out, 1: decoded command available.
- `cmd_ready`, in, 1: downstream accepts the command.
- `cmd_sprite`, out, 8: sprite id.
- `cmd_x`, out, 10: x coordinate.
- `cmd_y`, out, 9: y coordinate.
- `cmd_flags`, out, 2: bit0 = visible, bit1 = flip_h.
- `err_count`, out, 8: saturating count of discarded bytes and dropped commands.
- `busy`, out, 1: high when the state is not HUNT.

## Operation
Packet byte order:
- Byte 0: `SYNC_BYTE`.
- Byte 1: sprite id.
- Byte 2: x[9:8] in bits 1:0.
- Byte 3: x[7:0].
- Byte 4: bit0 = y[8], bits 2:1 = flags.
- Byte 5: y[7:0].
- Unused bits are ignored.

States:
- **HUNT**
  - Pop a byte whenever `q_empty` = 0.
  - Byte == `SYNC_BYTE` → PAYLOAD, with the byte index set to 0.
  - Any other byte is discarded and `err_count` increments.
- **PAYLOAD**
  - Pop a byte whenever `q_empty` = 0 and store it by index 0..4.
  - A `SYNC_BYTE` value here is payload data; no resync occurs.
  - After index 4 is consumed → CHECK.
- **CHECK** (one cycle, no pop)
  - Command in range → EMIT.
  - Otherwise → HUNT and `err_count` increments; nothing is emitted.
- **EMIT**
  - `cmd_valid` = 1; no pops.
  - On `cmd_valid & cmd_ready` → HUNT.

Other rules:
- `err_count` saturates at 255 and never wraps.
- `q_pop_front` is only asserted when `q_empty` = 0 in the same cycle.
- Reset, or reset mid-packet:
  - State goes to HUNT; the partial packet is discarded.
  - All outputs go to 0, including `cmd_*`, `err_count`, `busy` and `q_pop_front`.
  - Bytes still in the FIFO are untouched.

## Timing
- Maximum pop rate is 1 byte per cycle. An empty queue stalls the FSM in place with no timeout.
- Latency: last payload byte popped in cycle N → CHECK in N+1 → `cmd_valid` = 1 in N+2.
- Minimum time per packet is 8 cycles: 6 pops, CHECK, and the accept cycle.
- `cmd_*` fields are registered and stable from the rise of `cmd_valid` until acceptance.
- `cmd_valid` deasserts in the cycle after acceptance. HUNT may pop in that same cycle.
- `cmd_ready` is ignored while `cmd_valid` = 0.
- Discard and drop in the same cycle cannot occur, because they happen in different states.

## Configuration
- Macro: `RENDER_DEC_RANGE_CHECK_EN`.
- Defined:
  - CHECK compares x < `H_RES` and y < `V_RES`.
  - Out-of-range commands are dropped and counted.
- Undefined:
  - CHECK always proceeds to EMIT.
  - x and y pass through unmodified, with the full 10 and 9 bits.
  - `err_count` counts only HUNT discards.
  - Timing is identical, including the CHECK cycle.

## Test plan
- **Nominal packet.** Queue FF,07,01,2C,01,F0 with `cmd_ready` = 1. Expect `cmd_valid` 2 cycles after the 6th pop with sprite = 7, x = 300, y = 496−256… that is, y = {1,F0} = 496.
  - With the macro defined, y = 496 ≥ 480: the command is dropped and `err_count` = 1.
  - Repeat with byte4 = 00: emitted, y = 240, flags = 0.
- **Backpressure.** Two back-to-back valid packets with `cmd_ready` held at 0 for 10 cycles. Expect:
  - `cmd_*` stable throughout.
  - Zero pops during EMIT.
  - The second packet is emitted only after the first is accepted.
- **Resync and 0xFF payload.** Queue 12,34,FF,FF,00,10,02,20. Expect:
  - `err_count` = 2.
  - Emitted command: sprite = FF, x = 0x010, y = 0x020, flags = 01.
- **Underflow stall.** Deliver one packet with `q_empty` asserted for 5 cycles between bytes 3 and 4. Expect no pops while empty, and the same decoded command as the unstalled case.
- **Reset mid-packet.** Assert `reset` after 3 payload bytes. Expect:
  - All outputs = 0 and the state is HUNT.
  - The following full packet decodes correctly.
- **Saturation.** Queue 300 non-sync bytes. Expect `err_count` = 255 with no wrap.

Source files
------------

// File: rtl/render_cmd_decoder.sv
// render_cmd_decoder
// Pops sync-framed 6-byte render commands from the vga_render_q FIFO and
// presents each one as a parallel sprite-draw command on a valid/ready port.
//
// Ports:
//   clk50, reset          - clock; asynchronous active-high reset
//   q_dout, q_empty       - front byte of the render queue and its empty flag
//   q_pop_front           - pops the front byte (only while q_empty = 0)
//   cmd_valid, cmd_ready  - command handshake to the sprite renderer
//   cmd_sprite/x/y/flags  - decoded command fields (flags: bit0 visible, bit1 flip_h)
//   err_count             - saturating count of discarded bytes / dropped commands
//   busy                  - high whenever the decoder is not hunting for a sync byte
//
// Build option: define RENDER_DEC_RANGE_CHECK_EN to drop commands with
// x >= H_RES or y >= V_RES (counted in err_count). Otherwise every command passes.
module render_cmd_decoder #(
  parameter logic [7:0]  SYNC_BYTE = 8'hFF,
  parameter int unsigned H_RES     = 640,
  parameter int unsigned V_RES     = 480
) (
  input  logic       clk50,
  input  logic       reset,
  input  logic [7:0] q_dout,
  input  logic       q_empty,
  output logic       q_pop_front,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [7:0] cmd_sprite,
  output logic [9:0] cmd_x,
  output logic [8:0] cmd_y,
  output logic [1:0] cmd_flags,
  output logic [7:0] err_count,
  output logic       busy
);

  localparam int unsigned IDX_W       = 3;
  localparam int unsigned PAYLOAD_LEN = 5;

  // Resolutions beyond the coordinate field widths cannot be checked.
  if (H_RES > 1024 || V_RES > 512) begin : g_bad_res
    $error("render_cmd_decoder: H_RES/V_RES exceed coordinate field widths");
  end

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2,
    EMIT    = 2'd3
  } state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   idx, idx_next;
  logic               pop_c;
  logic               err_inc_c;
  logic               in_range_c;

  // Payload assembly registers, written directly in field layout.
  logic [7:0] sprite_q;
  logic [9:0] x_q;
  logic [8:0] y_q;
  logic [1:0] flags_q;

`ifdef RENDER_DEC_RANGE_CHECK_EN
  assign in_range_c = ({1'b0, x_q} < 11'(H_RES)) && ({1'b0, y_q} < 10'(V_RES));
`else
  assign in_range_c = 1'b1;
`endif

  // The pop must track q_empty in the same cycle, so it cannot be registered;
  // it is forced low while reset is held so the FIFO is left untouched.
  assign q_pop_front = pop_c & ~reset;

  // Next-state, pop and error-event decode.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    pop_c      = 1'b0;
    err_inc_c  = 1'b0;
    case (state)
      HUNT: begin
        if (!q_empty) begin
          pop_c = 1'b1;
          if (q_dout == SYNC_BYTE) begin
            state_next = PAYLOAD;
            idx_next   = '0;
          end else begin
            err_inc_c = 1'b1;
          end
        end
      end
      PAYLOAD: begin
        // A sync value here is plain payload; no resync.
        if (!q_empty) begin
          pop_c = 1'b1;
          if (idx == IDX_W'(PAYLOAD_LEN - 1)) begin
            state_next = CHECK;
          end else begin
            idx_next = idx + IDX_W'(1);
          end
        end
      end
      CHECK: begin
        if (in_range_c) begin
          state_next = EMIT;
        end else begin
          state_next = HUNT;
          err_inc_c  = 1'b1;
        end
      end
      EMIT: begin
        if (cmd_ready) begin
          state_next = HUNT;
        end
      end
      default: state_next = HUNT;
    endcase
  end

  // State, payload capture and registered outputs.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state      <= HUNT;
      idx        <= '0;
      sprite_q   <= '0;
      x_q        <= '0;
      y_q        <= '0;
      flags_q    <= '0;
      cmd_valid  <= 1'b0;
      cmd_sprite <= '0;
      cmd_x      <= '0;
      cmd_y      <= '0;
      cmd_flags  <= '0;
      err_count  <= '0;
      busy       <= 1'b0;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      cmd_valid <= (state_next == EMIT);
      busy      <= (state_next != HUNT);

      if (state == PAYLOAD && pop_c) begin
        case (idx)
          3'd0: sprite_q <= q_dout;
          3'd1: x_q[9:8] <= q_dout[1:0];
          3'd2: x_q[7:0] <= q_dout;
          3'd3: begin
            y_q[8]  <= q_dout[0];
            flags_q <= q_dout[2:1];
          end
          3'd4: y_q[7:0] <= q_dout;
          default: ;
        endcase
      end

      // Fields are latched once on entry to EMIT and held until acceptance.
      if (state == CHECK && state_next == EMIT) begin
        cmd_sprite <= sprite_q;
        cmd_x      <= x_q;
        cmd_y      <= y_q;
        cmd_flags  <= flags_q;
      end

      if (err_inc_c && err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_render_cmd_decoder.sv
// tb_render_cmd_decoder
// Directed bench for render_cmd_decoder: models the render FIFO, captures
// accepted commands and checks them against hand-computed values.
module tb_render_cmd_decoder;

  logic       clk50 = 1'b0;
  logic       reset;
  logic [7:0] q_dout;
  logic       q_empty;
  logic       q_pop_front;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_sprite;
  logic [9:0] cmd_x;
  logic [8:0] cmd_y;
  logic [1:0] cmd_flags;
  logic [7:0] err_count;
  logic       busy;

  always #10 clk50 = ~clk50;

  render_cmd_decoder dut (
    .clk50       (clk50),
    .reset       (reset),
    .q_dout      (q_dout),
    .q_empty     (q_empty),
    .q_pop_front (q_pop_front),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_sprite  (cmd_sprite),
    .cmd_x       (cmd_x),
    .cmd_y       (cmd_y),
    .cmd_flags   (cmd_flags),
    .err_count   (err_count),
    .busy        (busy)
  );

  typedef struct packed {
    logic [7:0] s;
    logic [9:0] x;
    logic [8:0] y;
    logic [1:0] f;
  } cmd_t;

  // Render FIFO model
  logic [7:0] fifo_mem [0:1023];
  int         rd = 0;
  int         wr = 0;
  logic       stall = 1'b0;

  assign q_empty = (rd == wr) || stall;
  assign q_dout  = fifo_mem[rd[9:0]];

  // Monitor: pops, latency markers, stability during backpressure, captures
  int   cyc = 0;
  int   last_pop_cyc = 0;
  int   rise_cyc = 0;
  int   bad_pops = 0;
  int   emit_pops = 0;
  int   unstable = 0;
  logic prev_valid = 1'b0;
  logic prev_acc = 1'b0;
  cmd_t prev_cmd;
  cmd_t cur;
  cmd_t got[$];

  always @(posedge clk50) begin
    cyc = cyc + 1;
    cur = {cmd_sprite, cmd_x, cmd_y, cmd_flags};
    if (q_pop_front) begin
      rd <= rd + 1;
      last_pop_cyc = cyc;
      if (q_empty) bad_pops = bad_pops + 1;
      if (cmd_valid) emit_pops = emit_pops + 1;
    end
    if (cmd_valid && !prev_valid) rise_cyc = cyc;
    if (cmd_valid && prev_valid && !prev_acc && cur != prev_cmd) unstable = unstable + 1;
    if (cmd_valid && cmd_ready) got.push_back(cur);
    prev_valid = cmd_valid;
    prev_acc   = cmd_valid && cmd_ready;
    prev_cmd   = cur;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic cmd_t mk(input logic [7:0] s, input logic [9:0] x,
                              input logic [8:0] y, input logic [1:0] f);
    return {s, x, y, f};
  endfunction

  task automatic push(input logic [7:0] b);
    fifo_mem[wr[9:0]] = b;
    wr++;
  endtask

  task automatic push6(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                       input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
    push(b0); push(b1); push(b2); push(b3); push(b4); push(b5);
  endtask

  task automatic wait_drain(input int budget, input string tag);
    int k = 0;
    while (rd != wr && k < budget) begin
      @(negedge clk50);
      k++;
    end
    chk(tag, 32'(rd == wr), 32'd1);
  endtask

  task automatic wait_got(input int n, input int budget, input string tag);
    int k = 0;
    while (got.size() < n && k < budget) begin
      @(negedge clk50);
      k++;
    end
    chk(tag, 32'(got.size() >= n), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk50);
    reset = 1'b1;
    @(negedge clk50);
    @(negedge clk50);
    reset = 1'b0;
    got.delete();
  endtask

  cmd_t exp_a, exp_b;
  int   rd_snap;
  int   k;

  initial begin
    reset     = 1'b1;
    cmd_ready = 1'b0;
    repeat (2) @(negedge clk50);

    // Reset state
    chk("rst_valid", 32'(cmd_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pop", 32'(q_pop_front), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_cmd", 32'({cmd_sprite, cmd_x, cmd_y, cmd_flags}), 32'd0);
    reset = 1'b0;

    // Nominal packet, y = 496
    cmd_ready = 1'b1;
    push6(8'hFF, 8'h07, 8'h01, 8'h2C, 8'h01, 8'hF0);
    wait_drain(50, "nom_drain");
    repeat (6) @(negedge clk50);
`ifdef RENDER_DEC_RANGE_CHECK_EN
    chk("nom_dropped", 32'(got.size()), 32'd0);
    chk("nom_drop_err", 32'(err_count), 32'd1);
`else
    chk("nom_count", 32'(got.size()), 32'd1);
    chk("nom_cmd", 32'(got[0]), 32'(mk(8'd7, 10'd300, 9'd496, 2'd0)));
    chk("nom_err", 32'(err_count), 32'd0);
`endif
    chk("nom_idle_valid", 32'(cmd_valid), 32'd0);

    // Nominal packet, y = 240, plus latency
    got.delete();
    push6(8'hFF, 8'h07, 8'h01, 8'h2C, 8'h00, 8'hF0);
    wait_got(1, 50, "nom2_timeout");
    chk("nom2_cmd", 32'(got[0]), 32'(mk(8'd7, 10'd300, 9'd240, 2'd0)));
    chk("nom2_latency", 32'(rise_cyc - last_pop_cyc), 32'd2);
    repeat (2) @(negedge clk50);
    chk("nom2_busy_after", 32'(busy), 32'd0);

    // Backpressure with two back-to-back packets
    do_reset();
    cmd_ready = 1'b0;
    exp_a = mk(8'h01, 10'd16, 9'd288, 2'd1);
    exp_b = mk(8'h02, 10'd639, 9'd5, 2'd2);
    push6(8'hFF, 8'h01, 8'h00, 8'h10, 8'h03, 8'h20);
    push6(8'hFF, 8'h02, 8'h02, 8'h7F, 8'h04, 8'h05);
    k = 0;
    while (!cmd_valid && k < 50) begin
      @(negedge clk50);
      k++;
    end
    chk("bp_valid_rise", 32'(cmd_valid), 32'd1);
    rd_snap = rd;
    repeat (10) @(negedge clk50);
    chk("bp_no_pop", 32'(rd), 32'(rd_snap));
    chk("bp_hold_cmd", 32'({cmd_sprite, cmd_x, cmd_y, cmd_flags}), 32'(exp_a));
    chk("bp_hold_valid", 32'(cmd_valid), 32'd1);
    cmd_ready = 1'b1;
    wait_got(2, 60, "bp_timeout");
    chk("bp_first", 32'(got[0]), 32'(exp_a));
    chk("bp_second", 32'(got[1]), 32'(exp_b));
    chk("bp_unstable", 32'(unstable), 32'd0);
    chk("bp_emit_pops", 32'(emit_pops), 32'd0);

    // Resync and 0xFF payload
    do_reset();
    push(8'h12); push(8'h34);
    push6(8'hFF, 8'hFF, 8'h00, 8'h10, 8'h02, 8'h20);
    wait_got(1, 60, "sync_timeout");
    chk("sync_cmd", 32'(got[0]), 32'(mk(8'hFF, 10'h010, 9'h020, 2'd1)));
    chk("sync_err", 32'(err_count), 32'd2);

    // Underflow stall between bytes 3 and 4
    do_reset();
    push(8'hFF); push(8'h07); push(8'h01); push(8'h2C);
    wait_drain(50, "stall_drain");
    stall = 1'b1;
    push(8'h00); push(8'hF0);
    rd_snap = rd;
    repeat (5) @(negedge clk50);
    chk("stall_no_pop", 32'(rd), 32'(rd_snap));
    chk("stall_busy", 32'(busy), 32'd1);
    stall = 1'b0;
    wait_got(1, 50, "stall_timeout");
    chk("stall_cmd", 32'(got[0]), 32'(mk(8'd7, 10'd300, 9'd240, 2'd0)));

    // Reset mid-packet
    do_reset();
    push(8'hFF); push(8'hAA); push(8'hBB); push(8'hCC);
    wait_drain(50, "mid_drain");
    chk("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    push(8'h55);
    @(negedge clk50);
    chk("mid_rst_valid", 32'(cmd_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_pop", 32'(q_pop_front), 32'd0);
    chk("mid_rst_err", 32'(err_count), 32'd0);
    chk("mid_rst_cmd", 32'({cmd_sprite, cmd_x, cmd_y, cmd_flags}), 32'd0);
    @(negedge clk50);
    chk("mid_fifo_kept", 32'(wr - rd), 32'd1);
    reset = 1'b0;
    got.delete();
    push6(8'hFF, 8'h03, 8'h01, 8'h00, 8'h01, 8'hDF);
    wait_got(1, 60, "mid_timeout");
    chk("mid_cmd", 32'(got[0]), 32'(mk(8'd3, 10'd256, 9'd479, 2'd0)));
    chk("mid_err", 32'(err_count), 32'd1);

    // Saturation
    do_reset();
    for (int i = 0; i < 300; i++) push(8'h00);
    wait_drain(400, "sat_drain");
    @(negedge clk50);
    chk("sat_err", 32'(err_count), 32'd255);
    chk("sat_busy", 32'(busy), 32'd0);

    chk("pop_while_empty", 32'(bad_pops), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
